unidad_control_multiciclo: RTL and testbench

Multi-cycle main control FSM for the RV32I core. It sequences every instruction through fetch, decode, execute, memory and register write-back. It drives the datapath mux selects and write strobes, runs the memory request/ready handshake, and produces the 2-bit `modo` consumed directly by `control_alu`. Illegal opcodes and memory time-outs are trapped into a sticky error state.

---
 rtl/unidad_control_multiciclo_pkg.sv | 46 ++++
 rtl/unidad_control_multiciclo_decodificador_opcode.sv | 29 ++
 rtl/unidad_control_multiciclo.sv | 186 ++++++++++++++++++
 tb/tb_unidad_control_multiciclo.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/unidad_control_multiciclo_pkg.sv
// rtl/unidad_control_multiciclo_pkg.sv - shared constants, encodings and enums for the multi-cycle control FSM
package unidad_control_multiciclo_pkg;

  // RV32I major opcodes handled by the core
  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_OPIMM  = 7'd19;
  localparam logic [6:0] OP_AUIPC  = 7'd23;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_OP     = 7'd51;
  localparam logic [6:0] OP_LUI    = 7'd55;
  localparam logic [6:0] OP_BRANCH = 7'd99;
  localparam logic [6:0] OP_JALR   = 7'd103;
  localparam logic [6:0] OP_JAL    = 7'd111;

  // modo encodings, shared with control_alu
  localparam logic [1:0] MODO_SUMA  = 2'b00;
  localparam logic [1:0] MODO_OPIMM = 2'b01;
  localparam logic [1:0] MODO_OP    = 2'b10;
  localparam logic [1:0] MODO_SALTO = 2'b11;

  // ALU operand A sources
  localparam logic [1:0] SEL_A_RS1    = 2'b00;
  localparam logic [1:0] SEL_A_PC     = 2'b01;
  localparam logic [1:0] SEL_A_PC_ANT = 2'b10;
  localparam logic [1:0] SEL_A_CERO   = 2'b11;

  // ALU operand B sources
  localparam logic [1:0] SEL_B_RS2    = 2'b00;
  localparam logic [1:0] SEL_B_IMM    = 2'b01;
  localparam logic [1:0] SEL_B_CUATRO = 2'b10;

  // Register-file write data sources
  localparam logic [1:0] SEL_RES_ALU = 2'b00;
  localparam logic [1:0] SEL_RES_MEM = 2'b01;
  localparam logic [1:0] SEL_RES_PC  = 2'b10;

  typedef enum logic [3:0] {
    INICIO, FETCH, DECODE, EJEC, SALTO, MEM_LEE, MEM_ESCR, ESCR_REG, ERROR
  } estado_t;

  typedef enum logic [3:0] {
    CL_OP, CL_OPIMM, CL_LUI, CL_AUIPC, CL_LOAD, CL_STORE,
    CL_JAL, CL_JALR, CL_BRANCH, CL_ILEGAL
  } clase_t;

endpackage

// File: rtl/unidad_control_multiciclo_decodificador_opcode.sv
// rtl/unidad_control_multiciclo_decodificador_opcode.sv - maps an opcode to its instruction class and legal flag
module decodificador_opcode
  import unidad_control_multiciclo_pkg::*;
(
  input  logic [6:0] opcode,
  output clase_t     clase,
  output logic       legal
);

  // Pure lookup; anything not listed is an illegal instruction
  always_comb begin
    clase = CL_ILEGAL;
    case (opcode)
      OP_OP:     clase = CL_OP;
      OP_OPIMM:  clase = CL_OPIMM;
      OP_LUI:    clase = CL_LUI;
      OP_AUIPC:  clase = CL_AUIPC;
      OP_LOAD:   clase = CL_LOAD;
      OP_STORE:  clase = CL_STORE;
      OP_JAL:    clase = CL_JAL;
      OP_JALR:   clase = CL_JALR;
      OP_BRANCH: clase = CL_BRANCH;
      default:   clase = CL_ILEGAL;
    endcase
  end

  assign legal = (clase != CL_ILEGAL);

endmodule

// File: rtl/unidad_control_multiciclo.sv
// rtl/unidad_control_multiciclo.sv - multi-cycle main control FSM for the RV32I core
module unidad_control_multiciclo
  import unidad_control_multiciclo_pkg::*;
#(
  parameter int ESPERA_MAX = 255
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic [6:0] opcode,
  input  logic       mem_listo,
  input  logic       cond_salto,
  output logic [1:0] modo,
  output logic [1:0] sel_a,
  output logic [1:0] sel_b,
  output logic       sel_pc,
  output logic       sel_dir,
  output logic [1:0] sel_res,
  output logic       escr_ir,
  output logic       escr_pc,
  output logic       escr_reg,
  output logic       escr_mem,
  output logic       mem_valido,
  output logic       error,
  output logic       error_causa
);

  // Counter is at least 8 bits, wider only if ESPERA_MAX needs it
  localparam int CW = ($clog2(ESPERA_MAX + 1) > 8) ? $clog2(ESPERA_MAX + 1) : 8;
  localparam logic [CW-1:0] ESPERA_LIM = CW'(ESPERA_MAX);

  estado_t         estado_q, estado_d;
  logic [CW-1:0]   espera_q, espera_d;
  logic            causa_q, causa_d;
  clase_t          clase;
  logic            legal;
  logic            espera_mem;
  logic            agotado;

  decodificador_opcode u_decodificador (
    .opcode (opcode),
    .clase  (clase),
    .legal  (legal)
  );

  // States that hold a memory request open and therefore may time out
  assign espera_mem = (estado_q == FETCH) || (estado_q == MEM_LEE) || (estado_q == MEM_ESCR);
  // mem_listo wins over the time-out in the same cycle
  assign agotado = (ESPERA_MAX != 0) && espera_mem && !mem_listo && (espera_q == ESPERA_LIM);

  // State, wait counter and trap cause registers
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      estado_q <= INICIO;
      espera_q <= '0;
      causa_q  <= 1'b0;
    end else begin
      estado_q <= estado_d;
      espera_q <= espera_d;
      causa_q  <= causa_d;
    end
  end

  // Next-state, trap cause and wait-counter update
  always_comb begin
    estado_d = estado_q;
    causa_d  = causa_q;
    case (estado_q)
      INICIO: estado_d = FETCH;
      FETCH: begin
        if (mem_listo) estado_d = DECODE;
        else if (agotado) begin
          estado_d = ERROR;
          causa_d  = 1'b1;
        end
      end
      DECODE: begin
        if (!legal) begin
          estado_d = ERROR;
          causa_d  = 1'b0;
        end else if (clase == CL_BRANCH) estado_d = SALTO;
        else estado_d = EJEC;
      end
      EJEC: begin
        case (clase)
          CL_OP, CL_OPIMM, CL_LUI, CL_AUIPC: estado_d = ESCR_REG;
          CL_LOAD:                           estado_d = MEM_LEE;
          CL_STORE:                          estado_d = MEM_ESCR;
          CL_JAL, CL_JALR:                   estado_d = FETCH;
          default: begin
            estado_d = ERROR;
            causa_d  = 1'b0;
          end
        endcase
      end
      SALTO: estado_d = FETCH;
      MEM_LEE, MEM_ESCR: begin
        if (mem_listo) estado_d = (estado_q == MEM_LEE) ? ESCR_REG : FETCH;
        else if (agotado) begin
          estado_d = ERROR;
          causa_d  = 1'b1;
        end
      end
      ESCR_REG: estado_d = FETCH;
      ERROR:    estado_d = ERROR;
      default:  estado_d = INICIO;
    endcase

    if ((estado_d != estado_q) || mem_listo || !espera_mem) espera_d = '0;
    else espera_d = espera_q + 1'b1;
  end

  // Datapath controls, strobes and handshake decoded from the current state
  always_comb begin
    modo        = MODO_SUMA;
    sel_a       = SEL_A_RS1;
    sel_b       = SEL_B_RS2;
    sel_pc      = 1'b0;
    sel_dir     = 1'b0;
    sel_res     = SEL_RES_ALU;
    escr_ir     = 1'b0;
    escr_pc     = 1'b0;
    escr_reg    = 1'b0;
    escr_mem    = 1'b0;
    mem_valido  = 1'b0;
    error       = 1'b0;
    error_causa = 1'b0;
    case (estado_q)
      FETCH: begin
        mem_valido = 1'b1;
        if (mem_listo) begin
          escr_ir = 1'b1;
          escr_pc = 1'b1;
          sel_a   = SEL_A_PC;
          sel_b   = SEL_B_CUATRO;
        end
      end
      DECODE: begin
        // Precompute the branch target into the ALU result register
        sel_a = SEL_A_PC_ANT;
        sel_b = SEL_B_IMM;
      end
      EJEC: begin
        case (clase)
          CL_OP:    modo = MODO_OP;
          CL_OPIMM: begin sel_b = SEL_B_IMM; modo = MODO_OPIMM; end
          CL_LUI:   begin sel_a = SEL_A_CERO; sel_b = SEL_B_IMM; end
          CL_AUIPC: begin sel_a = SEL_A_PC_ANT; sel_b = SEL_B_IMM; end
          CL_LOAD, CL_STORE: sel_b = SEL_B_IMM;
          CL_JAL, CL_JALR: begin
            // Link (PC = PC_ant+4) is written on the same edge as the jump
            sel_a    = (clase == CL_JAL) ? SEL_A_PC_ANT : SEL_A_RS1;
            sel_b    = SEL_B_IMM;
            escr_pc  = 1'b1;
            escr_reg = 1'b1;
            sel_res  = SEL_RES_PC;
          end
          default: ;
        endcase
      end
      SALTO: begin
        modo    = MODO_SALTO;
        sel_pc  = 1'b1;
        escr_pc = cond_salto;
      end
      MEM_LEE: begin
        mem_valido = 1'b1;
        sel_dir    = 1'b1;
      end
      MEM_ESCR: begin
        mem_valido = 1'b1;
        sel_dir    = 1'b1;
        escr_mem   = 1'b1;
      end
      ESCR_REG: begin
        escr_reg = 1'b1;
        sel_res  = (clase == CL_LOAD) ? SEL_RES_MEM : SEL_RES_ALU;
      end
      ERROR: begin
        error       = 1'b1;
        error_causa = causa_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// tb/tb_unidad_control_multiciclo.sv - directed self-checking bench for unidad_control_multiciclo
module tb_unidad_control_multiciclo;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic       mem_listo = 1'b0;
  logic       cond_salto = 1'b0;
  logic [1:0] modo, sel_a, sel_b, sel_res;
  logic       sel_pc, sel_dir, escr_ir, escr_pc, escr_reg, escr_mem;
  logic       mem_valido, error, error_causa;
  logic [16:0] outs;

  int n_pass = 0;
  int n_total = 0;

  logic [16:0] Z, F1, F0, D, EJ51, ER_ALU, EJ_IMM, ML, ER_MEM, MES;
  logic [16:0] SALTO1, SALTO0, JAL_E, JALR_E, E0, E1;

  always #5 clk = ~clk;

  unidad_control_multiciclo #(.ESPERA_MAX(4)) dut (
    .clk         (clk),
    .nreset      (nreset),
    .opcode      (opcode),
    .mem_listo   (mem_listo),
    .cond_salto  (cond_salto),
    .modo        (modo),
    .sel_a       (sel_a),
    .sel_b       (sel_b),
    .sel_pc      (sel_pc),
    .sel_dir     (sel_dir),
    .sel_res     (sel_res),
    .escr_ir     (escr_ir),
    .escr_pc     (escr_pc),
    .escr_reg    (escr_reg),
    .escr_mem    (escr_mem),
    .mem_valido  (mem_valido),
    .error       (error),
    .error_causa (error_causa)
  );

  assign outs = {modo, sel_a, sel_b, sel_pc, sel_dir, sel_res, escr_ir, escr_pc,
                 escr_reg, escr_mem, mem_valido, error, error_causa};

  // Packs an expected output set in the same order as outs
  function automatic logic [16:0] ev(input int m, a, b, pc, dir, res, ir, epc, ereg, emem, mv, err, ca);
    logic [1:0] m2, a2, b2, r2;
    m2 = m[1:0]; a2 = a[1:0]; b2 = b[1:0]; r2 = res[1:0];
    return {m2, a2, b2, pc[0], dir[0], r2, ir[0], epc[0], ereg[0], emem[0], mv[0], err[0], ca[0]};
  endfunction

  task automatic release_reset();
    nreset = 1'b0;
    mem_listo = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    nreset = 1'b0; mem_listo = 1'b1; opcode = 7'd51;
    repeat (2) @(negedge clk);
    #1;
    n_total++;
    if (outs !== Z) $display("FAIL reset_held: got %h want %h", outs, Z); else n_pass++;
    nreset = 1'b1;
    #1;
    n_total++;
    if (outs !== Z) $display("FAIL reset_inicio: got %h want %h", outs, Z); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_op();
    logic [16:0] exp [5];
    bit listo [5];
    exp = '{F1, D, EJ51, ER_ALU, F0};
    listo = '{1, 0, 0, 0, 0};
    opcode = 7'd51;
    for (int i = 0; i < 5; i++) begin
      mem_listo = listo[i]; #1;
      n_total++;
      if (outs !== exp[i]) $display("FAIL op51 cycle %0d: got %h want %h", i + 1, outs, exp[i]); else n_pass++;
      if (i != 4) @(negedge clk);
    end
  endtask

  task automatic test_load_wait();
    logic [16:0] exp [9];
    bit listo [9];
    exp = '{F1, D, EJ_IMM, ML, ML, ML, ML, ER_MEM, F0};
    listo = '{1, 0, 0, 0, 0, 0, 1, 0, 0};
    opcode = 7'd3;
    for (int i = 0; i < 9; i++) begin
      mem_listo = listo[i]; #1;
      n_total++;
      if (outs !== exp[i]) $display("FAIL load cycle %0d: got %h want %h", i + 1, outs, exp[i]); else n_pass++;
      if (i != 8) @(negedge clk);
    end
  endtask

  task automatic test_branch();
    logic [16:0] exp [4];
    bit listo [4];
    listo = '{1, 0, 0, 0};
    opcode = 7'd99;
    for (int r = 0; r < 2; r++) begin
      cond_salto = (r == 0);
      exp = '{F1, D, (r == 0) ? SALTO1 : SALTO0, F0};
      for (int i = 0; i < 4; i++) begin
        mem_listo = listo[i]; #1;
        n_total++;
        if (outs !== exp[i]) $display("FAIL branch cond=%0d cycle %0d: got %h want %h", cond_salto, i + 1, outs, exp[i]); else n_pass++;
        if (i != 3) @(negedge clk);
      end
    end
    cond_salto = 1'b0;
  endtask

  task automatic test_store();
    logic [16:0] exp [5];
    exp = '{F1, D, EJ_IMM, MES, F0};
    opcode = 7'd35;
    // mem_listo stays high outside request cycles and must be ignored there
    for (int i = 0; i < 5; i++) begin
      mem_listo = (i != 4); #1;
      n_total++;
      if (outs !== exp[i]) $display("FAIL store cycle %0d: got %h want %h", i + 1, outs, exp[i]); else n_pass++;
      if (i != 4) @(negedge clk);
    end
  endtask

  task automatic test_jal();
    logic [16:0] exp [4];
    for (int r = 0; r < 2; r++) begin
      opcode = (r == 0) ? 7'd111 : 7'd103;
      exp = '{F1, D, (r == 0) ? JAL_E : JALR_E, F0};
      for (int i = 0; i < 4; i++) begin
        mem_listo = (i == 0); #1;
        n_total++;
        if (outs !== exp[i]) $display("FAIL jump op=%0d cycle %0d: got %h want %h", opcode, i + 1, outs, exp[i]); else n_pass++;
        if (i != 3) @(negedge clk);
      end
    end
  endtask

  task automatic test_illegal();
    opcode = 7'h7F;
    for (int i = 0; i < 22; i++) begin
      mem_listo = (i == 0) || (i > 2); #1;
      n_total++;
      if (outs !== ((i == 0) ? F1 : (i == 1) ? D : E0))
        $display("FAIL illegal cycle %0d: got %h want %h", i + 1, outs, (i == 0) ? F1 : (i == 1) ? D : E0);
      else n_pass++;
      if (i != 21) @(negedge clk);
    end
    #1;
    nreset = 1'b0;
    #1;
    n_total++;
    if (outs !== Z) $display("FAIL async_reset_in_error: got %h want %h", outs, Z); else n_pass++;
  endtask

  task automatic test_timeout();
    opcode = 7'd51;
    release_reset();
    for (int i = 0; i < 8; i++) begin
      mem_listo = 1'b0; #1;
      n_total++;
      if (outs !== ((i < 5) ? F0 : E1)) $display("FAIL timeout cycle %0d: got %h want %h", i + 1, outs, (i < 5) ? F0 : E1);
      else n_pass++;
      if (i != 7) @(negedge clk);
    end
  endtask

  task automatic test_timeout_recovery();
    logic [16:0] exp [8];
    bit listo [8];
    exp = '{F0, F0, F0, F0, F1, D, EJ51, ER_ALU};
    listo = '{0, 0, 0, 0, 1, 0, 0, 0};
    opcode = 7'd51;
    release_reset();
    for (int i = 0; i < 8; i++) begin
      mem_listo = listo[i]; #1;
      n_total++;
      if (outs !== exp[i]) $display("FAIL timeout_edge cycle %0d: got %h want %h", i + 1, outs, exp[i]); else n_pass++;
      if (i != 7) @(negedge clk);
    end
  endtask

  initial begin
    Z      = '0;
    F1     = ev(0, 1, 2, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0);
    F0     = ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    D      = ev(0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    EJ51   = ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    ER_ALU = ev(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    EJ_IMM = ev(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    ML     = ev(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    ER_MEM = ev(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0);
    MES    = ev(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0);
    SALTO1 = ev(3, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    SALTO0 = ev(3, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    JAL_E  = ev(0, 2, 1, 0, 0, 2, 0, 1, 1, 0, 0, 0, 0);
    JALR_E = ev(0, 0, 1, 0, 0, 2, 0, 1, 1, 0, 0, 0, 0);
    E0     = ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    E1     = ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);

    test_reset();
    test_op();
    test_load_wait();
    test_branch();
    test_store();
    test_jal();
    test_illegal();
    test_timeout();
    test_timeout_recovery();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
